// File: rtl/sel_arbiter.sv
// Two-requester arbiter producing the registered select for a downstream 2:1 mux.
// Optional per-requester burst counters are enabled with `define SEL_ARBITER_STATS_EN.
module sel_arbiter #(
  parameter int USE_RR      = 1,
  parameter int MAX_BURST   = 8,
  parameter int SEL_A_LEVEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       sel,
  output logic [7:0] burst_cnt
`ifdef SEL_ARBITER_STATS_EN
  ,
  output logic [15:0] grants_a,
  output logic [15:0] grants_b
`endif
);

  generate
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("sel_arbiter: MAX_BURST must be in 1..255");
    end
    if (SEL_A_LEVEL != 0 && SEL_A_LEVEL != 1) begin : g_bad_sel
      $error("sel_arbiter: SEL_A_LEVEL must be 0 or 1");
    end
  endgenerate

  localparam logic SEL_A = (SEL_A_LEVEL != 0);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  state_t state;

  logic tie_a, idle_pick_a, at_max;
  logic start_a, start_b, go_idle;

  assign at_max      = (burst_cnt == 8'(MAX_BURST));
  assign idle_pick_a = req_a & (~req_b | tie_a);

  generate
    if (USE_RR != 0) begin : g_rr
      // Pointer to the most recent burst owner; reset to B so A wins the first tie.
      logic last_a;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_a <= 1'b0;
        else if (start_a) last_a <= 1'b1;
        else if (start_b) last_a <= 1'b0;
      end
      assign tie_a = ~last_a;
    end else begin : g_fp
      assign tie_a = 1'b1;
    end
  endgenerate

  // At a forced end the other side always wins if pending, so neither policy starves.
  always_comb begin
    start_a = 1'b0;
    start_b = 1'b0;
    go_idle = 1'b0;
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          start_a = idle_pick_a;
          start_b = ~idle_pick_a;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          if (req_b) start_b = 1'b1;
          else       go_idle = 1'b1;
        end else if (at_max) begin
          if (req_b) start_b = 1'b1;
          else       start_a = 1'b1;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          if (req_a) start_a = 1'b1;
          else       go_idle = 1'b1;
        end else if (at_max) begin
          if (req_a) start_a = 1'b1;
          else       start_b = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      sel       <= SEL_A;
      burst_cnt <= 8'd0;
    end else if (start_a) begin
      state     <= GNT_A;
      gnt_a     <= 1'b1;
      gnt_b     <= 1'b0;
      sel       <= SEL_A;
      burst_cnt <= 8'd1;
    end else if (start_b) begin
      state     <= GNT_B;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b1;
      sel       <= ~SEL_A;
      burst_cnt <= 8'd1;
    end else if (go_idle) begin
      state     <= IDLE;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      burst_cnt <= 8'd0;
    end else if (state != IDLE) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

`ifdef SEL_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_a <= 16'd0;
      grants_b <= 16'd0;
    end else begin
      if (start_a && grants_a != 16'hFFFF) grants_a <= grants_a + 16'd1;
      if (start_b && grants_b != 16'hFFFF) grants_b <= grants_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sel_arbiter.sv
// Bench for sel_arbiter: five builds driven by shared requests, each checked
// every cycle against a rule-level ownership model.
module tb_sel_arbiter;
  localparam int N = 5;
  localparam int RR[N] = '{1, 1, 0, 1, 0};
  localparam int MB[N] = '{8, 3, 4, 1, 2};
  localparam int SA[N] = '{0, 0, 0, 1, 0};

  logic clk, rst, req_a, req_b;
  logic [N-1:0] ga, gb, sl;
  logic [N-1:0][7:0] bc;
`ifdef SEL_ARBITER_STATS_EN
  logic [N-1:0][15:0] gra, grb;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int owner;  // -1 none, 0 A, 1 B
    int cnt;
    int last;
    bit sel;
    int na;
    int nb;
  } mdl_t;
  mdl_t m[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sel_arbiter #(.USE_RR(RR[g]), .MAX_BURST(MB[g]), .SEL_A_LEVEL(SA[g])) u_dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .gnt_a(ga[g]), .gnt_b(gb[g]), .sel(sl[g]), .burst_cnt(bc[g])
`ifdef SEL_ARBITER_STATS_EN
      , .grants_a(gra[g]), .grants_b(grb[g])
`endif
    );
  end

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(int i);
    mdl_t r;
    r.owner = -1; r.cnt = 0; r.last = 1; r.sel = SA[i] != 0; r.na = 0; r.nb = 0;
    return r;
  endfunction

  // One clock edge of the arbitration rules, written in terms of who owns the mux.
  function automatic mdl_t mdl_step(mdl_t s, bit ra, bit rb, int i);
    bit want[2];
    int win;
    want[0] = ra; want[1] = rb;
    win = -1;
    if (s.owner < 0) begin
      if (ra && rb)  win = (RR[i] != 0) ? 1 - s.last : 0;
      else if (ra)   win = 0;
      else if (rb)   win = 1;
    end else if (!want[s.owner]) begin
      win = want[1 - s.owner] ? 1 - s.owner : -1;
    end else if (s.cnt == MB[i]) begin
      win = want[1 - s.owner] ? 1 - s.owner : s.owner;
    end else begin
      s.cnt++;
      return s;
    end
    if (win < 0) begin
      s.owner = -1; s.cnt = 0;
    end else begin
      s.owner = win; s.cnt = 1; s.last = win;
      s.sel = (win == 0) ? (SA[i] != 0) : (SA[i] == 0);
      if (win == 0 && s.na < 65535) s.na++;
      if (win == 1 && s.nb < 65535) s.nb++;
    end
    return s;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      if (ga[i] === 1'b1 && gb[i] === 1'b1) begin
        $display("FAIL %s_excl[u%0d] observed both grants high expected at most one", tag, i);
        $fatal(1, "both grants high");
      end
      check({tag, "_gnt_a"}, i, 32'(ga[i]), 32'(m[i].owner == 0));
      check({tag, "_gnt_b"}, i, 32'(gb[i]), 32'(m[i].owner == 1));
      check({tag, "_sel"},   i, 32'(sl[i]), 32'(m[i].sel));
      check({tag, "_cnt"},   i, 32'(bc[i]), 32'(m[i].cnt));
`ifdef SEL_ARBITER_STATS_EN
      check({tag, "_grants_a"}, i, 32'(gra[i]), 32'(m[i].na));
      check({tag, "_grants_b"}, i, 32'(grb[i]), 32'(m[i].nb));
`endif
    end
  endtask

  task automatic cycle(input bit ra, input bit rb, input string tag);
    req_a = ra; req_b = rb;
    @(posedge clk);
    for (int i = 0; i < N; i++) m[i] = mdl_step(m[i], ra, rb, i);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) m[i] = mdl_reset(i);
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    do_reset();

    // Idle with no requests.
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, "idle");
      check("idle_sel0", 0, 32'(sl[0]), 32'd0);
      check("idle_cnt0", 0, 32'(bc[0]), 32'd0);
    end

    // Lone A burst of four cycles, then release to IDLE with sel held.
    for (int c = 1; c <= 4; c++) begin
      cycle(1, 0, "solo_a");
      check("solo_a_gnt", 0, 32'(ga[0]), 32'd1);
      check("solo_a_cnt", 0, 32'(bc[0]), 32'(c));
    end
    cycle(0, 0, "release");
    check("release_gnt", 0, 32'(ga[0]), 32'd0);
    check("release_sel", 0, 32'(sl[0]), 32'd0);

    // Both held: RR MAX 3 alternates every 3, FP MAX 4 every 4, MAX 1 every cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(1, 1, "both");
      check("both_rr3", 1, 32'(ga[1]), 32'(((c / 3) % 2) == 0));
      check("both_fp4", 2, 32'(ga[2]), 32'(((c / 4) % 2) == 0));
      check("both_rr1", 3, 32'(ga[3]), 32'((c % 2) == 0));
    end

    // Reset in the middle of a B burst drops grants without a clock edge.
    do_reset();
    for (int c = 0; c < 5; c++) cycle(1, 1, "pre_rst");
    check("mid_gnt_b", 1, 32'(gb[1]), 32'd1);
    check("mid_cnt", 1, 32'(bc[1]), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_gnt_b", 1, 32'(gb[1]), 32'd0);
    for (int i = 0; i < N; i++) m[i] = mdl_reset(i);
    check_all("async");
    #1 rst = 1'b0;
    cycle(1, 1, "post_rst");
    check("post_rst_a", 1, 32'(ga[1]), 32'd1);

    // Lone A for six cycles: MAX 2 build re-grants every second cycle.
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1, 0, "stats");
`ifdef SEL_ARBITER_STATS_EN
    check("stats_ga", 4, 32'(gra[4]), 32'd3);
    check("stats_gb", 4, 32'(grb[4]), 32'd0);
`endif

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, "rand");
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) m[i] = mdl_reset(i);
        check_all("rand_rst");
        #1 rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
